// File: rtl/mem_arbiter.sv
// Arbitrates one external memory port between instruction fetch and data access.
// Data has priority. A starvation counter bounds how long a waiting fetch can be
// held off. Optional `MEM_ARB_LOCK_EN` adds data_m_lock, which holds the data grant.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
`ifdef MEM_ARB_LOCK_EN
  input  logic        data_m_lock,
`endif
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX = 4'd15;

  state_t     state_reg, state_next;
  logic [3:0] starve_cnt_reg, starve_cnt_next;
  logic       instr_done, data_done, lock_hold;

  // The caller passes the post-update count, so the grant that completes the
  // starvation window hands the port to the fetch without an extra data grant.
  function automatic state_t arbitrate(input logic d_req, input logic i_req,
                                       input logic [3:0] cnt);
    state_t pick;
    pick = IDLE;
    if (d_req && i_req)
      pick = (cnt >= LIMIT) ? GNT_I : GNT_D;
    else if (d_req)
      pick = GNT_D;
    else if (i_req)
      pick = GNT_I;
    return pick;
  endfunction

  assign instr_done = (state_reg == GNT_I) && q_m_ack;
  assign data_done  = (state_reg == GNT_D) && q_m_ack;

`ifdef MEM_ARB_LOCK_EN
  assign lock_hold = (state_reg == GNT_D) && data_m_lock;
`else
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (instr_done)
      starve_cnt_next = '0;
    else if (data_done && !lock_hold) begin
      if (instr_m_access)
        starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? CNT_MAX : starve_cnt_reg + 4'd1;
      else
        starve_cnt_next = '0;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  state_next = arbitrate(data_m_access, instr_m_access, starve_cnt_reg);
      GNT_I: begin
        if (q_m_ack)
          state_next = arbitrate(data_m_access, instr_m_access, starve_cnt_next);
        else if (!instr_m_access)
          state_next = IDLE;
      end
      GNT_D: begin
        if (q_m_ack)
          state_next = lock_hold ? GNT_D
                                 : arbitrate(data_m_access, instr_m_access, starve_cnt_next);
        else if (!data_m_access)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data is shared. Only the granted requester sees an ack.
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (state_reg)
      GNT_I: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
      end
      GNT_D: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Define MEM_ARB_LOCK_EN to also exercise the lock.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [19:1] instr_m_addr;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
`ifdef MEM_ARB_LOCK_EN
  logic        data_m_lock;
`endif
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Per-cycle ack pattern with both requesters held and memory acking every cycle
  // (bit k = cycle k, cycle 0 is the IDLE cycle): 4 data, 1 instr, 4 data, 1 instr.
  localparam logic [10:0] EXP_D  = 11'b01111011110;
  localparam logic [10:0] EXP_I  = 11'b10000100000;
  localparam logic [7:0]  EXP_LD = 8'b01111110;
  localparam logic [7:0]  EXP_LI = 8'b10000000;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel),
`ifdef MEM_ARB_LOCK_EN
    .data_m_lock(data_m_lock),
`endif
    .data_m_ack(data_m_ack), .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .q_m_ack(q_m_ack), .q_m_data_in(q_m_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr_m_access = 1'b1; instr_m_addr = 19'h7FFFF;
    data_m_access = 1'b1; data_m_addr = 19'h7FFFF; data_m_data_out = 16'hFFFF;
    data_m_wr_en = 1'b1; data_m_bytesel = 2'b11;
    q_m_ack = 1'b1; q_m_data_in = 16'h0000;
`ifdef MEM_ARB_LOCK_EN
    data_m_lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL rst_access got=%b exp=0", q_m_access); else pass_cnt++;
    total_cnt++; if (q_m_wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b exp=0", q_m_wr_en); else pass_cnt++;
    total_cnt++; if (q_m_bytesel !== 2'b00) $display("FAIL rst_bytesel got=%b exp=00", q_m_bytesel); else pass_cnt++;
    total_cnt++; if (q_m_addr !== 19'h0) $display("FAIL rst_addr got=%h exp=0", q_m_addr); else pass_cnt++;
    total_cnt++; if (q_m_data_out !== 16'h0) $display("FAIL rst_data_out got=%h exp=0", q_m_data_out); else pass_cnt++;
    total_cnt++; if ({instr_m_ack, data_m_ack} !== 2'b00) $display("FAIL rst_acks got=%b exp=00", {instr_m_ack, data_m_ack}); else pass_cnt++;
    next_cycle();
    instr_m_access = 1'b0; instr_m_addr = '0;
    data_m_access = 1'b0; data_m_addr = '0; data_m_data_out = '0;
    data_m_wr_en = 1'b0; data_m_bytesel = 2'b00; q_m_ack = 1'b0;
    reset = 1'b1;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL rst_release_access got=%b exp=0", q_m_access); else pass_cnt++;
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_instr_read();
    next_cycle();
    instr_m_access = 1'b1; instr_m_addr = 19'h00010;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL ird_latency got=%b exp=0", q_m_access); else pass_cnt++;
    next_cycle();
    sample();
    total_cnt++; if (q_m_access !== 1'b1) $display("FAIL ird_access got=%b exp=1", q_m_access); else pass_cnt++;
    total_cnt++; if (q_m_addr !== 19'h00010) $display("FAIL ird_addr got=%h exp=00010", q_m_addr); else pass_cnt++;
    total_cnt++; if (q_m_wr_en !== 1'b0) $display("FAIL ird_wr_en got=%b exp=0", q_m_wr_en); else pass_cnt++;
    total_cnt++; if (q_m_bytesel !== 2'b11) $display("FAIL ird_bytesel got=%b exp=11", q_m_bytesel); else pass_cnt++;
    total_cnt++; if (instr_m_ack !== 1'b0) $display("FAIL ird_early_ack got=%b exp=0", instr_m_ack); else pass_cnt++;
    next_cycle();
    q_m_ack = 1'b1; q_m_data_in = 16'hBEEF; instr_m_access = 1'b0;
    sample();
    total_cnt++; if (instr_m_ack !== 1'b1) $display("FAIL ird_ack got=%b exp=1", instr_m_ack); else pass_cnt++;
    total_cnt++; if (instr_m_data_in !== 16'hBEEF) $display("FAIL ird_data got=%h exp=BEEF", instr_m_data_in); else pass_cnt++;
    total_cnt++; if (data_m_ack !== 1'b0) $display("FAIL ird_data_ack got=%b exp=0", data_m_ack); else pass_cnt++;
    next_cycle();
    q_m_ack = 1'b0;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL ird_idle_access got=%b exp=0", q_m_access); else pass_cnt++;
    total_cnt++; if ({instr_m_ack, data_m_ack} !== 2'b00) $display("FAIL ird_idle_acks got=%b exp=00", {instr_m_ack, data_m_ack}); else pass_cnt++;
    $display("instr read addr=00010 data=%h", instr_m_data_in);
  endtask

  task automatic test_both_requests();
    next_cycle();
    instr_m_access = 1'b1; instr_m_addr = 19'h00020;
    data_m_access = 1'b1; data_m_addr = 19'h00030; data_m_wr_en = 1'b0; data_m_bytesel = 2'b11;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL both_idle got=%b exp=0", q_m_access); else pass_cnt++;
    next_cycle();
    sample();
    total_cnt++; if (q_m_addr !== 19'h00030) $display("FAIL both_data_first got=%h exp=00030", q_m_addr); else pass_cnt++;
    total_cnt++; if (q_m_access !== 1'b1) $display("FAIL both_data_access got=%b exp=1", q_m_access); else pass_cnt++;
    next_cycle();
    q_m_ack = 1'b1; q_m_data_in = 16'h1234; data_m_access = 1'b0;
    sample();
    total_cnt++; if (data_m_ack !== 1'b1) $display("FAIL both_data_ack got=%b exp=1", data_m_ack); else pass_cnt++;
    total_cnt++; if (instr_m_ack !== 1'b0) $display("FAIL both_instr_quiet got=%b exp=0", instr_m_ack); else pass_cnt++;
    total_cnt++; if (data_m_data_in !== 16'h1234) $display("FAIL both_data_in got=%h exp=1234", data_m_data_in); else pass_cnt++;
    $display("data read addr=00030 data=%h", data_m_data_in);
    next_cycle();
    q_m_ack = 1'b0;
    sample();
    total_cnt++; if (q_m_access !== 1'b1) $display("FAIL both_no_bubble got=%b exp=1", q_m_access); else pass_cnt++;
    total_cnt++; if (q_m_addr !== 19'h00020) $display("FAIL both_instr_addr got=%h exp=00020", q_m_addr); else pass_cnt++;
    next_cycle();
    q_m_ack = 1'b1; q_m_data_in = 16'h5678; instr_m_access = 1'b0;
    sample();
    total_cnt++; if (instr_m_ack !== 1'b1) $display("FAIL both_instr_ack got=%b exp=1", instr_m_ack); else pass_cnt++;
    total_cnt++; if (data_m_ack !== 1'b0) $display("FAIL both_data_quiet got=%b exp=0", data_m_ack); else pass_cnt++;
    $display("instr read addr=00020 data=%h", instr_m_data_in);
    next_cycle();
    q_m_ack = 1'b0;
  endtask

  task automatic test_starvation();
    next_cycle();
    instr_m_access = 1'b1; instr_m_addr = 19'h00040;
    data_m_access = 1'b1; data_m_addr = 19'h00050; q_m_ack = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) next_cycle();
      if (k == 10) begin instr_m_access = 1'b0; data_m_access = 1'b0; end
      sample();
      total_cnt++; if (data_m_ack !== EXP_D[k]) $display("FAIL starve_data_ack cyc=%0d got=%b exp=%b", k, data_m_ack, EXP_D[k]); else pass_cnt++;
      total_cnt++; if (instr_m_ack !== EXP_I[k]) $display("FAIL starve_instr_ack cyc=%0d got=%b exp=%b", k, instr_m_ack, EXP_I[k]); else pass_cnt++;
      $display("starve cyc=%0d data_ack=%b instr_ack=%b", k, data_m_ack, instr_m_ack);
    end
    next_cycle();
    q_m_ack = 1'b0;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL starve_end_idle got=%b exp=0", q_m_access); else pass_cnt++;
  endtask

  task automatic test_data_write();
    next_cycle();
    data_m_access = 1'b1; data_m_addr = 19'h12345; data_m_data_out = 16'hA55A;
    data_m_bytesel = 2'b01; data_m_wr_en = 1'b1;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL wr_latency got=%b exp=0", q_m_access); else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      q_m_ack = (k == 1);
      sample();
      total_cnt++; if (q_m_wr_en !== 1'b1) $display("FAIL wr_wr_en cyc=%0d got=%b exp=1", k, q_m_wr_en); else pass_cnt++;
      total_cnt++; if (q_m_bytesel !== 2'b01) $display("FAIL wr_bytesel cyc=%0d got=%b exp=01", k, q_m_bytesel); else pass_cnt++;
      total_cnt++; if (q_m_data_out !== 16'hA55A) $display("FAIL wr_data_out cyc=%0d got=%h exp=A55A", k, q_m_data_out); else pass_cnt++;
      total_cnt++; if (q_m_addr !== 19'h12345) $display("FAIL wr_addr cyc=%0d got=%h exp=12345", k, q_m_addr); else pass_cnt++;
      total_cnt++; if (data_m_ack !== (k == 1)) $display("FAIL wr_ack cyc=%0d got=%b exp=%b", k, data_m_ack, (k == 1)); else pass_cnt++;
    end
    $display("data write addr=12345 data=A55A bytesel=01");
    // Requester still held at the ack, so it is regranted; abort that grant.
    next_cycle();
    q_m_ack = 1'b0; data_m_access = 1'b0;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL abort_access got=%b exp=0", q_m_access); else pass_cnt++;
    total_cnt++; if (data_m_ack !== 1'b0) $display("FAIL abort_ack got=%b exp=0", data_m_ack); else pass_cnt++;
    next_cycle();
    q_m_ack = 1'b1;
    sample();
    total_cnt++; if (data_m_ack !== 1'b0) $display("FAIL idle_ack_ignored got=%b exp=0", data_m_ack); else pass_cnt++;
    $display("abort then stray memory ack in idle");
    next_cycle();
    q_m_ack = 1'b0; data_m_wr_en = 1'b0; data_m_bytesel = 2'b11;
  endtask

  task automatic test_reset_mid_grant();
    next_cycle();
    instr_m_access = 1'b1; data_m_access = 1'b1; data_m_addr = 19'h00055; q_m_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      sample();
      total_cnt++; if (data_m_ack !== EXP_D[k]) $display("FAIL pre_rst_ack cyc=%0d got=%b exp=%b", k, data_m_ack, EXP_D[k]); else pass_cnt++;
    end
    next_cycle();
    q_m_ack = 1'b0;
    sample();
    total_cnt++; if (q_m_access !== 1'b1) $display("FAIL pre_rst_grant got=%b exp=1", q_m_access); else pass_cnt++;
    #2;
    reset = 1'b0; q_m_ack = 1'b1;
    #1;
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL mid_rst_access got=%b exp=0", q_m_access); else pass_cnt++;
    total_cnt++; if ({instr_m_ack, data_m_ack} !== 2'b00) $display("FAIL mid_rst_acks got=%b exp=00", {instr_m_ack, data_m_ack}); else pass_cnt++;
    $display("reset asserted during data grant");
    next_cycle();
    instr_m_access = 1'b0; data_m_access = 1'b0; q_m_ack = 1'b0; reset = 1'b1;
    sample();
    total_cnt++; if (q_m_access !== 1'b0) $display("FAIL post_rst_idle got=%b exp=0", q_m_access); else pass_cnt++;
    // A cleared counter gives the full four data grants before the fetch.
    next_cycle();
    instr_m_access = 1'b1; data_m_access = 1'b1; q_m_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      if (k == 5) begin instr_m_access = 1'b0; data_m_access = 1'b0; end
      sample();
      total_cnt++; if (data_m_ack !== EXP_D[k]) $display("FAIL post_rst_data cyc=%0d got=%b exp=%b", k, data_m_ack, EXP_D[k]); else pass_cnt++;
      total_cnt++; if (instr_m_ack !== EXP_I[k]) $display("FAIL post_rst_instr cyc=%0d got=%b exp=%b", k, instr_m_ack, EXP_I[k]); else pass_cnt++;
    end
    $display("post reset arbitration sequence checked");
    next_cycle();
    q_m_ack = 1'b0;
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    next_cycle();
    instr_m_access = 1'b1; data_m_access = 1'b1; data_m_lock = 1'b1; q_m_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      if (k == 6) begin data_m_access = 1'b0; data_m_lock = 1'b0; end
      if (k == 7) instr_m_access = 1'b0;
      sample();
      total_cnt++; if (data_m_ack !== EXP_LD[k]) $display("FAIL lock_data cyc=%0d got=%b exp=%b", k, data_m_ack, EXP_LD[k]); else pass_cnt++;
      total_cnt++; if (instr_m_ack !== EXP_LI[k]) $display("FAIL lock_instr cyc=%0d got=%b exp=%b", k, instr_m_ack, EXP_LI[k]); else pass_cnt++;
      $display("lock cyc=%0d data_ack=%b instr_ack=%b", k, data_m_ack, instr_m_ack);
    end
    next_cycle();
    q_m_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_instr_read();
    test_both_requests();
    test_starvation();
    test_data_write();
    test_reset_mid_grant();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
